gpio_pad_ctrl: RTL

Per-pad controller for the 1.8V GPIO pad cell. It accepts pad configuration through a valid/ready port and applies it with a glitch-safe sequence: drive off, settle, apply, settle, re-enable. It registers output data to the pad. It synchronises, debounces and edge-detects pad input data. One instance sits between the SoC GPIO register block and each pad cell.

---
 rtl/gpio_pad_ctrl_pkg.sv | 43 ++++
 rtl/gpio_pad_ctrl_in.sv | 89 ++++++++
 rtl/gpio_pad_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/gpio_pad_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_pad_ctrl_pkg                                                    |
// | Shared types for the per-pad GPIO controller.                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package gpio_pad_ctrl_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    MODE_IN = 2'b00,
    MODE_PP = 2'b01,
    MODE_OD = 2'b10,
    MODE_OS = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    PULL_NONE = 2'b00,
    PULL_PD   = 2'b01,
    PULL_PU   = 2'b10,
    PULL_KEEP = 2'b11
  } pull_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_QUIESCE = 2'b01,
    ST_APPLY   = 2'b10,
    ST_ENABLE  = 2'b11
  } state_e;

  typedef struct packed {
    logic [3:0] ds;
    logic       sr;
    logic       co;
    logic [1:0] ste;
    logic       ie;
    pull_e      pull;
    mode_e      mode;
  } pad_cfg_t;

endpackage
`default_nettype wire

// File: rtl/gpio_pad_ctrl_in.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_in_debounce                                                     |
// | Pad input synchroniser, debounce, edge detect and input-enable gate. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gpio_in_debounce
  import gpio_pad_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ie_i,
  input  logic di_i,
  output logic data_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_syncOut;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], di_i};
    end
  end

  assign w_syncOut = r_sync[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYC == 0) begin : g_bypass
      logic r_prev;

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          r_prev <= 1'b0;
        end else begin
          r_prev <= ie_i & w_syncOut;
        end
      end

      assign data_o = ie_i & w_syncOut;
      assign rise_o = ie_i & w_syncOut & ~r_prev;
      assign fall_o = ie_i & ~w_syncOut & r_prev;
    end else begin : g_debounce
      logic [CNT_W-1:0] r_cnt;
      logic             r_data;
      logic             r_rise;
      logic             r_fall;

      // IE low holds everything cleared so re-enabling starts from a known 0.
      always_ff @(posedge clk_i) begin
        if (!rst_ni || !ie_i) begin
          r_cnt  <= '0;
          r_data <= 1'b0;
          r_rise <= 1'b0;
          r_fall <= 1'b0;
        end else begin
          r_rise <= 1'b0;
          r_fall <= 1'b0;
          if (w_syncOut != r_data) begin
            if (r_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
              r_cnt  <= '0;
              r_data <= w_syncOut;
              r_rise <= w_syncOut;
              r_fall <= ~w_syncOut;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else begin
            r_cnt <= '0;
          end
        end
      end

      // Gate combinationally so disabling IE drops the data without a fall pulse.
      assign data_o = r_data & ie_i;
      assign rise_o = r_rise & ie_i;
      assign fall_o = r_fall & ie_i;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/gpio_pad_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_pad_ctrl                                                        |
// | Per-pad controller: glitch-safe reconfiguration, output and input.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gpio_pad_ctrl
  import gpio_pad_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC   = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 8,
  parameter int HAS_VBIAS    = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cfg_valid_i,
  output logic       cfg_ready_o,
  input  logic [1:0] cfg_mode_i,
  input  logic [3:0] cfg_ds_i,
  input  logic       cfg_sr_i,
  input  logic       cfg_co_i,
  input  logic [1:0] cfg_pull_i,
  input  logic [1:0] cfg_ste_i,
  input  logic       cfg_ie_i,
  input  logic       out_data_i,
  output logic       busy_o,
  output logic       in_data_o,
  output logic       in_rise_o,
  output logic       in_fall_o,
  output logic       pad_do_o,
  output logic       pad_sr_o,
  output logic       pad_co_o,
  output logic       pad_oe_o,
  output logic       pad_odp_o,
  output logic       pad_odn_o,
  output logic       pad_ie_o,
  output logic       pad_pu_o,
  output logic       pad_pd_o,
  output logic [3:0] pad_ds_o,
  output logic [1:0] pad_ste_o,
  input  logic [1:0] pad_di_i
);

  state_e           r_state;
  state_e           w_stateNext;
  logic [CNT_W-1:0] r_settleCnt;
  logic             r_cfgReady;
  pad_cfg_t         r_shadow;
  logic             w_handshake;
  logic             w_settleDone;
  logic [3:0]       w_dsApplied;
  logic             w_unusedDi;

  logic       r_padDo, r_padSr, r_padCo, r_padOe, r_padOdp, r_padOdn;
  logic       r_padIe, r_padPu, r_padPd;
  logic [3:0] r_padDs;
  logic [1:0] r_padSte;

  assign w_handshake  = cfg_valid_i & r_cfgReady;
  assign w_settleDone = (r_settleCnt == CNT_W'(SETTLE_CYC - 1));
  assign w_unusedDi   = pad_di_i[1];

  // Without VBIAS the pad ignores OE when DS[1:0] is non-zero.
  assign w_dsApplied = (HAS_VBIAS != 0) ? r_shadow.ds : {r_shadow.ds[3:2], 2'b00};

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:    if (w_handshake)  w_stateNext = ST_QUIESCE;
      ST_QUIESCE: if (w_settleDone) w_stateNext = ST_APPLY;
      ST_APPLY:   if (w_settleDone) w_stateNext = ST_ENABLE;
      ST_ENABLE:  w_stateNext = ST_IDLE;
      default:    w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_settleCnt <= '0;
      r_cfgReady  <= 1'b0;
      r_shadow    <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_cfgReady <= (w_stateNext == ST_IDLE);
      if ((r_state != w_stateNext) || (r_state == ST_IDLE)) begin
        r_settleCnt <= '0;
      end else begin
        r_settleCnt <= r_settleCnt + CNT_W'(1);
      end
      if (w_handshake) begin
        r_shadow <= '{ds:   cfg_ds_i,
                      sr:   cfg_sr_i,
                      co:   cfg_co_i,
                      ste:  cfg_ste_i,
                      ie:   cfg_ie_i,
                      pull: pull_e'(cfg_pull_i),
                      mode: mode_e'(cfg_mode_i)};
      end
    end
  end

  // Pad drive: OE drops on acceptance, attributes change mid-sequence, OE returns last.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_padDo  <= 1'b0;
      r_padSr  <= 1'b0;
      r_padCo  <= 1'b0;
      r_padOe  <= 1'b0;
      r_padOdp <= 1'b0;
      r_padOdn <= 1'b0;
      r_padIe  <= 1'b0;
      r_padPu  <= 1'b0;
      r_padPd  <= 1'b0;
      r_padDs  <= '0;
      r_padSte <= '0;
    end else begin
      r_padDo <= out_data_i;
      if (w_handshake) begin
        r_padOe <= 1'b0;
      end else if ((r_state == ST_APPLY) && w_settleDone) begin
        r_padOe <= (r_shadow.mode != MODE_IN);
      end
      if ((r_state == ST_QUIESCE) && w_settleDone) begin
        r_padDs  <= w_dsApplied;
        r_padSr  <= r_shadow.sr;
        r_padCo  <= r_shadow.co;
        r_padSte <= r_shadow.ste;
        r_padIe  <= r_shadow.ie;
        r_padPu  <= (r_shadow.pull == PULL_PU) || (r_shadow.pull == PULL_KEEP);
        r_padPd  <= (r_shadow.pull == PULL_PD) || (r_shadow.pull == PULL_KEEP);
        r_padOdn <= (r_shadow.mode == MODE_OD);
        r_padOdp <= (r_shadow.mode == MODE_OS);
      end
    end
  end

  gpio_in_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_inDebounce (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .ie_i  (r_padIe),
    .di_i  (pad_di_i[0]),
    .data_o(in_data_o),
    .rise_o(in_rise_o),
    .fall_o(in_fall_o)
  );

  assign cfg_ready_o = r_cfgReady;
  assign busy_o      = (r_state != ST_IDLE);
  assign pad_do_o    = r_padDo;
  assign pad_sr_o    = r_padSr;
  assign pad_co_o    = r_padCo;
  assign pad_oe_o    = r_padOe;
  assign pad_odp_o   = r_padOdp;
  assign pad_odn_o   = r_padOdn;
  assign pad_ie_o    = r_padIe;
  assign pad_pu_o    = r_padPu;
  assign pad_pd_o    = r_padPd;
  assign pad_ds_o    = r_padDs;
  assign pad_ste_o   = r_padSte;

endmodule
`default_nettype wire
